// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the 32-entry register file: per-register in-flight
// write counters, decode-stage hazard stall, and writeback retirement.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rs,
  input  logic [ADDR_W-1:0]         issue_rt,
  input  logic                      issue_use_rs,
  input  logic                      issue_use_rt,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic                      issue_wr,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_reg,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue_accept,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic                      underflow_err,
  output logic [ADDR_W+CNT_W-1:0]   pending_total
);

  localparam int TOT_W = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec_q, busy_vec_d, uf_vec;
  logic [TOT_W-1:0]    pending_total_q, pending_total_d;
  logic                underflow_err_q, underflow_err_d;
  logic                rs_hazard, rt_hazard, rd_hazard;

  // A single outstanding write that retires this cycle lands on the negedge,
  // before the register file is read, so it does not block a source.
  always_comb begin
    rs_hazard = issue_use_rs && (issue_rs != '0) && (cnt_q[issue_rs] != '0) &&
                !((cnt_q[issue_rs] == CNT_W'(1)) && wb_valid && (wb_reg == issue_rs));
    rt_hazard = issue_use_rt && (issue_rt != '0) && (cnt_q[issue_rt] != '0) &&
                !((cnt_q[issue_rt] == CNT_W'(1)) && wb_valid && (wb_reg == issue_rt));
    rd_hazard = issue_wr && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX) &&
                !(wb_valid && (wb_reg == issue_rd));
  end

  assign stall        = issue_valid & (rs_hazard | rt_hazard | rd_hazard) & ~flush;
  assign issue_accept = issue_valid & ~stall & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_d[gi]  = '0;
        assign uf_vec[gi] = 1'b0;
      end else begin : g_reg
        logic inc, dec;
        assign inc = issue_accept & issue_wr & (issue_rd == ADDR_W'(gi));
        assign dec = wb_valid & (wb_reg == ADDR_W'(gi));
        assign cnt_d[gi] = flush                                ? '0 :
                           (inc & ~dec)                         ? cnt_q[gi] + CNT_W'(1) :
                           (dec & ~inc & (cnt_q[gi] != '0))     ? cnt_q[gi] - CNT_W'(1) :
                                                                  cnt_q[gi];
        assign uf_vec[gi] = ~flush & dec & ~inc & (cnt_q[gi] == '0);
      end
      assign busy_vec_d[gi] = (cnt_d[gi] != '0);
    end
  endgenerate

  always_comb begin
    pending_total_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_total_d = pending_total_d + TOT_W'(cnt_d[i]);
    end
  end

  assign underflow_err_d = underflow_err_q | (|uf_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      busy_vec_q      <= '0;
      pending_total_q <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      busy_vec_q      <= busy_vec_d;
      pending_total_q <= pending_total_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign busy_vec      = busy_vec_q;
  assign pending_total = pending_total_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard: expected registered state is queued
// when stimulus is driven and checked after the following posedge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_wr;
  logic [4:0]  issue_rs, issue_rt, issue_rd, wb_reg;
  logic        wb_valid, flush;
  logic        stall, issue_accept, underflow_err;
  logic [31:0] busy_vec;
  logic [6:0]  pending_total;

  typedef struct packed {
    logic [31:0] busy;
    logic [6:0]  total;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .stall(stall), .issue_accept(issue_accept), .busy_vec(busy_vec),
    .underflow_err(underflow_err), .pending_total(pending_total)
  );

  task automatic idle();
    issue_valid = 0; issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0;
    issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = rd;
  endtask

  task automatic test_reset();
    drive_issue(5);
    tick();
    n_checks++;
    if (busy_vec !== 32'h20) begin
      n_fail++; $display("FAIL reset_pre busy=%h expected %h", busy_vec, 32'h20);
    end
    idle();
    #3 rst = 1;
    #1;
    n_checks++;
    if (busy_vec !== 0 || pending_total !== 0 || underflow_err !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL reset_async busy=%h total=%0d uf=%b stall=%b expected 0 0 0 0",
               busy_vec, pending_total, underflow_err, stall);
    end
    #2 rst = 0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_raw();
    drive_issue(5);
    #1;
    n_checks++;
    if (issue_accept !== 1) begin
      n_fail++; $display("FAIL raw_issue accept=%b expected 1", issue_accept);
    end
    exp_q.push_back('{busy: 32'h20, total: 7'd1, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL raw_set busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    issue_valid = 1; issue_rs = 5; issue_use_rs = 1;
    #1;
    n_checks++;
    if (stall !== 1 || issue_accept !== 0) begin
      n_fail++; $display("FAIL raw_stall stall=%b accept=%b expected 1 0", stall, issue_accept);
    end
    wb_valid = 1; wb_reg = 5;
    #1;
    n_checks++;
    if (stall !== 0 || issue_accept !== 1) begin
      n_fail++; $display("FAIL raw_bypass stall=%b accept=%b expected 0 1", stall, issue_accept);
    end
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL raw_retire busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    $display("test_raw done");
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 3; k++) begin
      drive_issue(7);
      exp_q.push_back('{busy: 32'h80, total: 7'(k), uf: 1'b0});
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({busy_vec, pending_total, underflow_err} !== e) begin
        n_fail++; $display("FAIL sat_fill%0d busy=%h total=%0d expected busy=%h total=%0d",
                           k, busy_vec, pending_total, e.busy, e.total);
      end
    end
    // Count of 3 with a retiring write still blocks a reader of r7.
    idle();
    issue_valid = 1; issue_rs = 7; issue_use_rs = 1; wb_valid = 1; wb_reg = 7;
    #1;
    n_checks++;
    if (stall !== 1) begin
      n_fail++; $display("FAIL sat_src_multi stall=%b expected 1", stall);
    end
    drive_issue(7);
    #1;
    n_checks++;
    if (stall !== 1 || issue_accept !== 0) begin
      n_fail++; $display("FAIL sat_dst_stall stall=%b accept=%b expected 1 0", stall, issue_accept);
    end
    wb_valid = 1; wb_reg = 7;
    #1;
    n_checks++;
    if (stall !== 0 || issue_accept !== 1) begin
      n_fail++; $display("FAIL sat_dst_wb stall=%b accept=%b expected 0 1", stall, issue_accept);
    end
    exp_q.push_back('{busy: 32'h80, total: 7'd3, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL sat_hold busy=%h total=%0d expected busy=%h total=%0d",
                         busy_vec, pending_total, e.busy, e.total);
    end
    for (int k = 2; k >= 0; k--) begin
      idle();
      wb_valid = 1; wb_reg = 7;
      exp_q.push_back('{busy: (k != 0) ? 32'h80 : 32'h0, total: 7'(k), uf: 1'b0});
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({busy_vec, pending_total, underflow_err} !== e) begin
        n_fail++; $display("FAIL sat_drain%0d busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                           k, busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
      end
    end
    idle();
    $display("test_saturation done");
  endtask

  task automatic test_reg0();
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 0;
    issue_rs = 0; issue_use_rs = 1; issue_rt = 0; issue_use_rt = 1;
    wb_valid = 1; wb_reg = 0;
    #1;
    n_checks++;
    if (stall !== 0 || issue_accept !== 1) begin
      n_fail++; $display("FAIL reg0_issue stall=%b accept=%b expected 0 1", stall, issue_accept);
    end
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL reg0_state busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    $display("test_reg0 done");
  endtask

  task automatic test_underflow();
    idle();
    wb_valid = 1; wb_reg = 9;
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b1});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL uf_set busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    flush = 1;
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b1});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if (underflow_err !== e.uf) begin
      n_fail++; $display("FAIL uf_sticky_flush uf=%b expected %b", underflow_err, e.uf);
    end
    idle();
    #2 rst = 1;
    #1;
    n_checks++;
    if (underflow_err !== 0) begin
      n_fail++; $display("FAIL uf_clear_rst uf=%b expected 0", underflow_err);
    end
    #2 rst = 0;
    tick();
    $display("test_underflow done");
  endtask

  task automatic test_flush();
    logic [4:0] rds [3];
    rds[0] = 3; rds[1] = 3; rds[2] = 4;
    for (int k = 0; k < 3; k++) begin
      drive_issue(rds[k]);
      exp_q.push_back('{busy: (k < 2) ? 32'h08 : 32'h18, total: 7'(k + 1), uf: 1'b0});
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({busy_vec, pending_total, underflow_err} !== e) begin
        n_fail++; $display("FAIL flush_setup%0d busy=%h total=%0d expected busy=%h total=%0d",
                           k, busy_vec, pending_total, e.busy, e.total);
      end
    end
    drive_issue(3);
    issue_rs = 3; issue_use_rs = 1;
    wb_valid = 1; wb_reg = 4; flush = 1;
    #1;
    n_checks++;
    if (stall !== 0 || issue_accept !== 0) begin
      n_fail++; $display("FAIL flush_comb stall=%b accept=%b expected 0 0", stall, issue_accept);
    end
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL flush_clear busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    drive_issue(2);
    exp_q.push_back('{busy: 32'h04, total: 7'd1, uf: 1'b0});
    tick();
    // Issue to r1 and retire r2 in the same cycle.
    drive_issue(1);
    wb_valid = 1; wb_reg = 2;
    exp_q.push_back('{busy: 32'h02, total: 7'd1, uf: 1'b0});
    tick();
    // Issue and retire r1 together: count holds at 1.
    drive_issue(1);
    wb_valid = 1; wb_reg = 1;
    exp_q.push_back('{busy: 32'h02, total: 7'd1, uf: 1'b0});
    tick();
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (e.total !== 7'd1) begin
        n_fail++; $display("FAIL b2b_queue%0d total=%0d expected 1", k, e.total);
      end
    end
    n_checks++;
    if (busy_vec !== 32'h02 || pending_total !== 7'd1) begin
      n_fail++; $display("FAIL b2b_state busy=%h total=%0d expected busy=%h total=1",
                         busy_vec, pending_total, 32'h02);
    end
    idle();
    issue_valid = 1; issue_rt = 1; issue_use_rt = 1;
    #1;
    n_checks++;
    if (stall !== 1) begin
      n_fail++; $display("FAIL b2b_rt_stall stall=%b expected 1", stall);
    end
    issue_use_rt = 0;
    #1;
    n_checks++;
    if (stall !== 0 || issue_accept !== 1) begin
      n_fail++; $display("FAIL b2b_rt_unused stall=%b accept=%b expected 0 1", stall, issue_accept);
    end
    idle();
    wb_valid = 1; wb_reg = 1;
    exp_q.push_back('{busy: 32'h0, total: 7'd0, uf: 1'b0});
    tick();
    e = exp_q.pop_front(); n_checks++;
    if ({busy_vec, pending_total, underflow_err} !== e) begin
      n_fail++; $display("FAIL b2b_drain busy=%h total=%0d uf=%b expected busy=%h total=%0d uf=%b",
                         busy_vec, pending_total, underflow_err, e.busy, e.total, e.uf);
    end
    idle();
    $display("test_back_to_back done");
  endtask

  initial begin
    idle();
    rst = 1;
    #12 rst = 0;
    tick();
    test_reset();
    test_raw();
    test_saturation();
    test_reg0();
    test_underflow();
    test_flush();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL queue_empty size=%0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Tracks in-flight writes to the 32-entry register file in the pipelined datapath. It holds a per-register pending-write counter and raises a stall when the decode stage issues an instruction whose sources, or whose saturated destination, are still pending. Pending writes are set at issue and retired by the writeback port that drives the register file's write enable (register file writes on negedge clk).

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked
ADDR_W, 5, register index width; log2(NUM_REGS)
CNT_W, 2, per-register pending counter width; max in-flight writes per register = 2^CNT_W-1 = 3

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
issue_valid  in  1  decode stage presents an instruction this cycle
issue_rs  in  ADDR_W  first source register
issue_rt  in  ADDR_W  second source register
issue_use_rs  in  1  instruction actually reads rs
issue_use_rt  in  1  instruction actually reads rt
issue_rd  in  ADDR_W  destination register
issue_wr  in  1  instruction writes rd (regwrite at decode)
wb_valid  in  1  writeback retiring a write this cycle (same as register-file regwrite)
wb_reg  in  ADDR_W  register being written back (same as register-file writereg)
flush  in  1  pipeline flush; discard all pending writes
stall  out  1  combinational; hold decode, do not advance instruction
issue_accept  out  1  combinational; issue_valid & ~stall
busy_vec  out  NUM_REGS  registered; bit i = counter[i] != 0; bit 0 always 0
underflow_err  out  1  sticky; writeback to register with zero pending count
pending_total  out  ADDR_W+CNT_W  registered; sum of all counters

Behaviour:
- Reset (async, rst=1): all counters 0, busy_vec=0, pending_total=0, underflow_err=0. stall=0 while issue_valid=0. Reset mid-operation discards all pending state immediately.
- Index 0: never incremented, never decremented, never busy; wb to 0 is ignored and does not set underflow_err.
- Source hazard per source s in {rs,rt} with use bit set and s!=0: hazard if counter[s]!=0, EXCEPT when counter[s]==1 and wb_valid & wb_reg==s in the same cycle (write lands on negedge, read sees it; no stall).
- Destination hazard: issue_wr & rd!=0 & counter[rd]==2^CNT_W-1 and no same-cycle wb to rd -> stall.
- stall = issue_valid & (any source hazard | destination hazard) & ~flush. flush forces stall=0, issue_accept=0.
- Posedge update, priority order:
  1. flush=1: all counters -> 0; wb and issue ignored; underflow_err preserved.
  2. Otherwise, per register r: inc = issue_accept & issue_wr & issue_rd==r; dec = wb_valid & wb_reg==r.
     inc&dec -> unchanged; inc only -> +1; dec only with counter>0 -> -1; dec only with counter==0 -> stays 0, underflow_err<=1.
- busy_vec and pending_total reflect counters after the edge (1-cycle latency from issue/wb).
- underflow_err clears only on rst.
- Counter never wraps: saturation is prevented by the destination stall.
- Independent registers update in parallel in the same cycle (issue to r1 and wb to r2 both apply).

Test Plan:
- Reset then idle: rst pulse mid-cycle -> busy_vec=0, pending_total=0, underflow_err=0, stall=0 without waiting for clk.
- RAW stall: issue rd=5 wr=1, accepted; next cycle issue rs=5 use_rs=1 -> stall=1, busy_vec[5]=1; wb_valid wb_reg=5 same cycle -> stall=0, issue_accept=1; next edge busy_vec[5]=0.
- Saturation: three accepted issues to rd=7, no wb -> pending_total=3; fourth issue rd=7 -> stall=1; wb_reg=7 that cycle -> accepted, counter stays 3.
- Register 0: issue rd=0 wr=1 and rs=0 -> never stall, busy_vec=0; wb_reg=0 with count 0 -> underflow_err stays 0.
- Underflow: wb_valid wb_reg=9 with counter[9]=0 -> underflow_err=1 after edge, counter[9]=0; stays 1 through a flush, clears on rst.
- Flush priority: counters r3=2, r4=1; flush with simultaneous issue rd=3 and wb_reg=4 -> stall=0, issue_accept=0, next edge busy_vec=0, pending_total=0.
